match_reporter: RTL and testbench
=================================

Name: match_reporter

Overview:
- Sits directly downstream of the IP/MAC/port comparator bank. It frames the comparator outputs per packet and consumes their sticky match flags.
- It waits out the comparator pipeline after end-of-packet, then builds one 32-bit report word per frame. Report words are buffered in a small FIFO that the Atom reads.
- It drives the comparators' clear so their buffers and match flags reset between frames.

Parameters:
- NUM_CMP, 4, number of comparator match inputs (1..8)
- PIPE_LAT, 3, cycles from the last data word entering a comparator to its final match value being valid
- FIFO_DEPTH, 4, report FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  system clock
- n_rst  input  1  synchronous active-low reset
- valid  input  1  data word present on comparator data_in this cycle
- sop  input  1  first word of frame (qualified by valid)
- eop  input  1  last word of frame (qualified by valid)
- match_vec  input  NUM_CMP  sticky match flags from the comparators
- in_ready  output  1  high when a new frame or word may be presented
- cmp_clear  output  1  one-cycle clear to all comparators
- rd_en  input  1  Atom pops the head report
- report_valid  output  1  FIFO not empty
- report_data  output  32  head report word
- drop_count  output  8  saturating count of reports lost to a full FIFO

Behaviour:
- Interface: one clock clk. Reset n_rst is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values:
  - State IDLE; FIFO emptied.
  - in_ready=1, cmp_clear=0, report_valid=0, report_data=0, drop_count=0.
  - frame_id=0, word counter=0.
- FSM states: IDLE, IN_FRAME, DRAIN, REPORT, CLEAR.
  - IDLE: valid&sop → IN_FRAME; word count=1. valid without sop is ignored. sop&eop in the same word → DRAIN directly.
  - IN_FRAME: each valid increments the word count, saturating at 255. valid&eop → DRAIN with drain counter=PIPE_LAT-1. A valid&sop mid-frame is treated as an ordinary word.
  - DRAIN: decrement the drain counter; at 0 → REPORT.
  - REPORT: sample match_vec and form the report word; push it or drop it; → CLEAR.
  - CLEAR: cmp_clear=1 for exactly this cycle. Increment frame_id (16-bit, wraps 0xFFFF→0x0000); zero the word count; → IDLE.
- in_ready is 1 only in IDLE and IN_FRAME. Upstream must hold data while in_ready=0; any valid in DRAIN, REPORT or CLEAR is ignored.
- Report word layout:
  - [31:16] frame_id
  - [15:8] word count
  - [7:0] match_vec zero-extended to 8 bits
- FIFO rules:
  - report_data shows the head entry combinationally from the FIFO registers; it is 0 when empty.
  - rd_en when empty is ignored.
  - Push while full is dropped and drop_count increments (saturates at 255), unless rd_en is high that same cycle, in which case pop and push both occur and nothing is dropped.
- Latency: eop word at cycle t. Report sampled at t+PIPE_LAT+1. report_valid is high at t+PIPE_LAT+2. cmp_clear is high in cycle t+PIPE_LAT+2. Next sop is accepted at t+PIPE_LAT+3.
- Reset asserted mid-frame or mid-drain returns to the reset state next edge. No report is pushed and cmp_clear is not pulsed; comparators share n_rst.

Optional Feature:
- Macro MATCH_ONLY_EN.
- Defined: REPORT pushes only if match_vec is nonzero. Frames with no match still advance frame_id, pulse cmp_clear, and never touch drop_count.
- Undefined: every frame produces a report push attempt.

Decomposition:
- Package sniffer_pkg holds:
  - state enum reporter_state_t
  - packed struct report_t {frame_id[15:0], word_cnt[7:0], match[7:0]}
  - constants REPORT_W=32, MAX_CMP=8
- Sub-module report_fifo: synchronous FIFO parameterised by depth and width, with push, pop, full, empty and head outputs. match_reporter instantiates it once.

Test Plan:
- Reset, then a 3-word frame with match_vec=4'b0010 asserted before the drain ends → report_data=0x0000_0302, report_valid at eop+5, one cmp_clear pulse at eop+5 (PIPE_LAT=3).
- Single-word frame with sop&eop and match_vec=0 → report 0x0000_0100 without the macro; no report with MATCH_ONLY_EN defined; frame_id still advances to 1.
- 300-word frame → word count field saturates at 0xFF.
- Five matching frames with no rd_en, FIFO_DEPTH=4 → four reports queued, drop_count=1. Sixth frame whose push coincides with rd_en → no drop, drop_count stays 1.
- valid and sop during DRAIN with in_ready=0 → ignored; word count and frame_id unaffected.
- n_rst low for one cycle mid-frame → all outputs return to reset values, no report pushed; the next frame reports frame_id=0.

Source files
------------

// File: rtl/sniffer_pkg.sv
// Shared types and constants for the comparator-bank match reporter.
package sniffer_pkg;

    localparam int unsigned REPORT_W = 32;
    localparam int unsigned MAX_CMP  = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StInFrame = 3'd1,
        StDrain   = 3'd2,
        StReport  = 3'd3,
        StClear   = 3'd4
    } reporter_state_t;

    typedef struct packed {
        logic [15:0] frame_id;
        logic [7:0]  word_cnt;
        logic [7:0]  match;
    } report_t;

endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO with combinational head output (zero when empty).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module report_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_n_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/match_reporter.sv
// Frames comparator match flags per packet and queues one report word per frame.
// Define MATCH_ONLY_EN to queue reports only for frames with a nonzero match vector.
module match_reporter
    import sniffer_pkg::*;
#(
    parameter int unsigned NUM_CMP    = 4,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                valid,
    input  logic                sop,
    input  logic                eop,
    input  logic [NUM_CMP-1:0]  match_vec,
    output logic                in_ready,
    output logic                cmp_clear,
    input  logic                rd_en,
    output logic                report_valid,
    output logic [REPORT_W-1:0] report_data,
    output logic [7:0]          drop_count
);

    reporter_state_t r_state;
    reporter_state_t w_state_nxt;
    logic [7:0]      r_word_cnt;
    logic [7:0]      w_word_cnt_nxt;
    logic [7:0]      r_drain_cnt;
    logic [7:0]      w_drain_cnt_nxt;
    logic [15:0]     r_frame_id;
    logic [15:0]     w_frame_id_nxt;
    logic [7:0]      r_drop_cnt;

    logic [MAX_CMP-1:0] w_match_ext;
    report_t            w_report;
    logic               w_push_req;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    always_comb begin
        w_match_ext              = '0;
        w_match_ext[NUM_CMP-1:0] = match_vec;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_word_cnt_nxt  = r_word_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_frame_id_nxt  = r_frame_id;
        case (r_state)
            StIdle: begin
                if (valid && sop) begin
                    w_word_cnt_nxt = 8'd1;
                    if (eop) begin
                        w_state_nxt     = StDrain;
                        w_drain_cnt_nxt = 8'(PIPE_LAT - 1);
                    end else begin
                        w_state_nxt = StInFrame;
                    end
                end
            end
            StInFrame: begin
                if (valid) begin
                    if (r_word_cnt != 8'hFF) begin
                        w_word_cnt_nxt = r_word_cnt + 8'd1;
                    end
                    if (eop) begin
                        w_state_nxt     = StDrain;
                        w_drain_cnt_nxt = 8'(PIPE_LAT - 1);
                    end
                end
            end
            StDrain: begin
                if (r_drain_cnt == 8'd0) begin
                    w_state_nxt = StReport;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 8'd1;
                end
            end
            StReport: begin
                w_state_nxt = StClear;
            end
            StClear: begin
                w_frame_id_nxt = r_frame_id + 16'd1;
                w_word_cnt_nxt = 8'd0;
                w_state_nxt    = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= StIdle;
            r_word_cnt  <= 8'd0;
            r_drain_cnt <= 8'd0;
            r_frame_id  <= 16'd0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_frame_id  <= w_frame_id_nxt;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign w_report.frame_id = r_frame_id;
    assign w_report.word_cnt = r_word_cnt;
    assign w_report.match    = w_match_ext;

`ifdef MATCH_ONLY_EN
    assign w_push_req = (r_state == StReport) && (|match_vec);
`else
    assign w_push_req = (r_state == StReport);
`endif

    // A pop in the same cycle frees the slot, so only an un-popped full FIFO drops.
    assign w_drop = w_push_req && w_full && !rd_en;

    report_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REPORT_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_n_rst (n_rst),
        .i_push  (w_push_req),
        .i_pop   (rd_en),
        .i_data  (w_report),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (report_data)
    );

    assign in_ready     = (r_state == StIdle) || (r_state == StInFrame);
    assign cmp_clear    = (r_state == StClear);
    assign report_valid = !w_empty;
    assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_match_reporter.sv
// Randomised directed bench for match_reporter against a queue-based report model.
module tb_match_reporter;

    localparam int unsigned NUM_CMP    = 4;
    localparam int unsigned PIPE_LAT   = 3;
    localparam int unsigned FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               valid;
    logic               sop;
    logic               eop;
    logic [NUM_CMP-1:0] match_vec;
    logic               in_ready;
    logic               cmp_clear;
    logic               rd_en;
    logic               report_valid;
    logic [31:0]        report_data;
    logic [7:0]         drop_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [15:0] m_fid;
    int          m_drops;

    match_reporter #(
        .NUM_CMP    (NUM_CMP),
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .valid        (valid),
        .sop          (sop),
        .eop          (eop),
        .match_vec    (match_vec),
        .in_ready     (in_ready),
        .cmp_clear    (cmp_clear),
        .rd_en        (rd_en),
        .report_valid (report_valid),
        .report_data  (report_data),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fid   = 16'd0;
        m_drops = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_cmp_clear"}, cmp_clear, 0);
        check({tag, "_report_valid"}, report_valid, 0);
        check({tag, "_report_data"}, report_data, 0);
        check({tag, "_drop_count"}, drop_count, 0);
    endtask

    task automatic do_reset(input int cycles);
        n_rst = 1'b0;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        n_rst = 1'b1;
        model_reset();
    endtask

    // Pop the head, checking it against the model queue (empty pops must be ignored).
    task automatic pop_check();
        check("rv_before_pop", report_valid, (q.size() != 0));
        if (q.size() != 0) check("pop_data", report_data, q[0]);
        else check("empty_data", report_data, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic send_frame(input int n, input logic [NUM_CMP-1:0] m, input bit rd_push,
                              input bit noisy);
        logic [31:0] exp_word;
        logic [7:0]  cnt;
        bit          attempt;
        bit          popped;
        if (noisy) begin
            // valid without sop in IDLE is not a frame start
            valid = 1'b1; sop = 1'b0; eop = 1'($urandom);
            check("in_ready_idle_noise", in_ready, 1);
            tick();
        end
        for (int i = 0; i < n; i++) begin
            if (noisy && ($urandom_range(0, 3) == 0)) begin
                valid = 1'b0; sop = 1'($urandom); eop = 1'($urandom);
                tick();
            end
            valid = 1'b1;
            sop   = (i == 0) || (noisy && ($urandom_range(0, 4) == 0));
            eop   = (i == n - 1);
            if (i < 2 || i == n - 1) check("in_ready_frame", in_ready, 1);
            tick();
        end
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        match_vec = m;
        for (int k = 0; k < PIPE_LAT; k++) begin
            if (noisy) begin
                valid = 1'b1; sop = 1'b1; eop = 1'($urandom);
            end
            check("in_ready_drain", in_ready, 0);
            check("cmp_clear_drain", cmp_clear, 0);
            tick();
        end
        check("in_ready_report", in_ready, 0);
        check("rv_at_report", report_valid, (q.size() != 0));
        popped = 1'b0;
        if (rd_push) begin
            rd_en = 1'b1;
            if (q.size() != 0) begin
                check("report_data_at_push", report_data, q[0]);
                popped = 1'b1;
            end
        end
        tick();
        rd_en = 1'b0;
        if (popped) void'(q.pop_front());
        cnt      = (n > 255) ? 8'hFF : 8'(n);
        exp_word = {m_fid, cnt, 8'(m)};
`ifdef MATCH_ONLY_EN
        attempt = (m != '0);
`else
        attempt = 1'b1;
`endif
        if (attempt) begin
            if (q.size() < FIFO_DEPTH) q.push_back(exp_word);
            else if (m_drops < 255) m_drops++;
        end
        m_fid = m_fid + 16'd1;
        if (noisy) begin
            valid = 1'b1; sop = 1'b1; eop = 1'($urandom);
        end
        check("cmp_clear_pulse", cmp_clear, 1);
        check("in_ready_clear", in_ready, 0);
        check("rv_after_push", report_valid, (q.size() != 0));
        check("drop_count", drop_count, 32'(m_drops));
        tick();
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        check("cmp_clear_done", cmp_clear, 0);
        check("in_ready_idle", in_ready, 1);
    endtask

    initial begin
        n_rst = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0;
        rd_en = 1'b0; match_vec = '0;
        model_reset();

        // Reset values
        do_reset(2);
        check_reset_outputs("reset");

        // 3-word frame, match 0010
        send_frame(3, 4'b0010, 1'b0, 1'b0);
        check("first_report_const", report_data, 32'h0000_0302);
        pop_check();

        // Single-word sop&eop frame with no match
        send_frame(1, 4'b0000, 1'b0, 1'b0);
        check("frame_id_adv", 32'(m_fid), 2);
        while (q.size() != 0) pop_check();
        pop_check();

        // Word count saturates at 0xFF
        send_frame(300, 4'(($urandom_range(1, 15))), 1'b0, 1'b0);
        check("sat_count_field", report_data[15:8], 8'hFF);
        pop_check();

        // Overflow: five matching frames, then a sixth whose push meets rd_en
        for (int f = 0; f < 5; f++) send_frame(2, 4'(($urandom_range(1, 15))), 1'b0, 1'b0);
        check("overflow_drops", drop_count, 1);
        send_frame(2, 4'(($urandom_range(1, 15))), 1'b1, 1'b0);
        check("no_drop_with_pop", drop_count, 1);
        while (q.size() != 0) pop_check();

        // Noise during drain/report/clear must be ignored
        send_frame(4, 4'b1001, 1'b0, 1'b1);
        pop_check();

        // Mid-frame reset
        valid = 1'b1; sop = 1'b1; eop = 1'b0; tick();
        sop = 1'b0; tick();
        n_rst = 1'b0; tick();
        n_rst = 1'b1; valid = 1'b0;
        model_reset();
        check_reset_outputs("midrst");
        for (int i = 0; i < PIPE_LAT + 3; i++) begin
            check("midrst_no_clear", cmp_clear, 0);
            check("midrst_no_report", report_valid, 0);
            tick();
        end
        send_frame(2, 4'b0100, 1'b0, 1'b0);
        check("midrst_fid_zero", report_data[31:16], 16'h0000);
        pop_check();

        // Randomised frames with random pops
        for (int f = 0; f < 30; f++) begin
            send_frame($urandom_range(1, 12), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'b1);
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) pop_check();
        end
        while (q.size() != 0) pop_check();
        check("final_empty", report_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
